// File: rtl/cont_crescente_rega.sv
// Programmable up-counter/timer for the irrigation controller: counts qualified ticks 0..MAX_COUNT.
// Optional continuous (wrap-around) mode with a Carry pulse is enabled by defining CONT_WRAP_EN.
module cont_crescente_rega #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 5,
  parameter int PRESCALE  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Hold,
  input  logic             Tick,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Carry
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_RUN   = 2'd1;
  localparam logic [1:0]       ST_DONE  = 2'd2;
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_C   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);
  localparam logic [3:0]       PRE_LAST = 4'(PRESCALE - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [3:0]       pre_r;
  logic [3:0]       pre_s;
  logic             busy_r;
  logic             done_r;
  logic             carry_r;
  logic             carry_s;
  logic             accepted_s;

  // Advances the count by one step, wrapping to zero only from the terminal value.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] nxt;
    if (cur == MAX_C) begin
      nxt = ZERO_C;
    end else begin
      nxt = cur + ONE_C;
    end
    return nxt;
  endfunction

  // Next-state and next-count decode; Abort outranks Start, which outranks Tick.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    pre_s      = pre_r;
    carry_s    = 1'b0;
    accepted_s = Tick & ~Hold;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s = ST_RUN;
          count_s = ZERO_C;
          pre_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
          count_s = ZERO_C;
          pre_s   = 4'd0;
        end
      end
      ST_RUN: begin
        if (Abort) begin
          state_s = ST_IDLE;
          count_s = ZERO_C;
          pre_s   = 4'd0;
        end else if (Start) begin
          state_s = ST_RUN;
          count_s = ZERO_C;
          pre_s   = 4'd0;
        end else if (accepted_s) begin
          if (pre_r == PRE_LAST) begin
            pre_s   = 4'd0;
            count_s = step_count(count_r);
`ifdef CONT_WRAP_EN
            // Continuous mode: the terminal step wraps and flags Carry, never leaving RUN.
            if (count_r == MAX_C) begin
              carry_s = 1'b1;
            end else begin
              carry_s = 1'b0;
            end
`else
            if (step_count(count_r) == MAX_C) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RUN;
            end
`endif
          end else begin
            pre_s = pre_r + 4'd1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (Abort) begin
          state_s = ST_IDLE;
          count_s = ZERO_C;
          pre_s   = 4'd0;
        end else if (Start) begin
          state_s = ST_RUN;
          count_s = ZERO_C;
          pre_s   = 4'd0;
        end else begin
          state_s = ST_DONE;
          count_s = MAX_C;
          pre_s   = 4'd0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = ZERO_C;
        pre_s   = 4'd0;
      end
    endcase
  end

  // State, count and status flags; flags decode the next state so they line up with state_r.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_C;
      pre_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      pre_r   <= pre_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
      carry_r <= carry_s;
    end
  end

  assign Count = count_r;
  assign Busy  = busy_r;
  assign Done  = done_r;
  assign Carry = carry_r;

endmodule

// File: tb/tb_cont_crescente_rega.sv
// Directed bench for cont_crescente_rega: default instance (PRESCALE=1) and a PRESCALE=2 instance.
module tb_cont_crescente_rega;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic       Hold = 1'b0;
  logic       Tick = 1'b0;
  logic [2:0] Count;
  logic       Busy;
  logic       Done;
  logic       Carry;

  logic       start2 = 1'b0;
  logic       tick2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       hold2 = 1'b0;
  logic [2:0] count2;
  logic       busy2;
  logic       done2;
  logic       carry2;

  int checks = 0;
  int errors = 0;

  cont_crescente_rega #(.WIDTH(3), .MAX_COUNT(5), .PRESCALE(1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Hold(Hold), .Tick(Tick),
    .Count(Count), .Busy(Busy), .Done(Done), .Carry(Carry)
  );

  cont_crescente_rega #(.WIDTH(3), .MAX_COUNT(5), .PRESCALE(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(start2), .Abort(abort2), .Hold(hold2), .Tick(tick2),
    .Count(count2), .Busy(busy2), .Done(done2), .Carry(carry2)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] c, input logic b,
                           input logic d, input logic ca);
    check({tag, ".count"}, {5'd0, Count}, {5'd0, c});
    check({tag, ".busy"}, {7'd0, Busy}, {7'd0, b});
    check({tag, ".done"}, {7'd0, Done}, {7'd0, d});
    check({tag, ".carry"}, {7'd0, Carry}, {7'd0, ca});
  endtask

  initial begin
    cyc();
    check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    // Tick alone in IDLE does nothing
    Tick = 1'b1;
    cyc();
    check_all("idle_tick", 3'd0, 1'b0, 1'b0, 1'b0);

    Start = 1'b1;
    cyc();
    check_all("start", 3'd0, 1'b1, 1'b0, 1'b0);
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_all("run", 3'(i), 1'b1, 1'b0, 1'b0);
    end
    cyc();
`ifdef CONT_WRAP_EN
    check_all("reach5", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    check_all("wrap0", 3'd0, 1'b1, 1'b0, 1'b1);
    cyc();
    check_all("wrap1", 3'd1, 1'b1, 1'b0, 1'b0);
`else
    check_all("reach5", 3'd5, 1'b0, 1'b1, 1'b0);
    cyc();
    check_all("hold5", 3'd5, 1'b0, 1'b1, 1'b0);
`endif

    // Restart, then pause with Hold during ticks 3-4
    Tick = 1'b0;
    Start = 1'b1;
    cyc();
    check_all("restart", 3'd0, 1'b1, 1'b0, 1'b0);
    Start = 1'b0;
    Tick = 1'b1;
    cyc();
    check_all("h_t1", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc();
    check_all("h_t2", 3'd2, 1'b1, 1'b0, 1'b0);
    Hold = 1'b1;
    cyc();
    check_all("h_t3", 3'd2, 1'b1, 1'b0, 1'b0);
    cyc();
    check_all("h_t4", 3'd2, 1'b1, 1'b0, 1'b0);
    Hold = 1'b0;
    cyc();
    check_all("h_rel", 3'd3, 1'b1, 1'b0, 1'b0);

    // Start with simultaneous Tick at Count=3 restarts and drops the tick
    Start = 1'b1;
    cyc();
    check_all("start_tick", 3'd0, 1'b1, 1'b0, 1'b0);
    Start = 1'b0;
    cyc();
    cyc();
    cyc();
    check_all("back3", 3'd3, 1'b1, 1'b0, 1'b0);

    // Abort beats Start
    Abort = 1'b1;
    Start = 1'b1;
    cyc();
    check_all("abort_start", 3'd0, 1'b0, 1'b0, 1'b0);
    Abort = 1'b0;
    Start = 1'b0;
    cyc();
    check_all("idle_after_abort", 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run at Count=4
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check_all("pre_reset4", 3'd4, 1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    cyc();
    check_all("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    cyc();
    cyc();
    check_all("post_reset_tick", 3'd0, 1'b0, 1'b0, 1'b0);

`ifndef CONT_WRAP_EN
    // Abort from DONE
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check_all("done_again", 3'd5, 1'b0, 1'b1, 1'b0);
    Abort = 1'b1;
    cyc();
    check_all("abort_done", 3'd0, 1'b0, 1'b0, 1'b0);
    Abort = 1'b0;
`endif
    Tick = 1'b0;

    // PRESCALE=2 instance, Tick every third cycle
    start2 = 1'b1;
    cyc();
    check("p2.start_busy", {7'd0, busy2}, 8'd1);
    start2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick2 = 1'b1;
      cyc();
      tick2 = 1'b0;
      check($sformatf("p2.count_t%0d", k), {5'd0, count2}, 8'(k / 2));
`ifdef CONT_WRAP_EN
      check($sformatf("p2.done_t%0d", k), {7'd0, done2}, 8'd0);
`else
      check($sformatf("p2.done_t%0d", k), {7'd0, done2}, (k == 10) ? 8'd1 : 8'd0);
`endif
      cyc();
      cyc();
    end
    check("p2.carry", {7'd0, carry2}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
